framebuffer_loader: RTL and testbench

Upstream writer for the framebuffer's port A, which the display path currently leaves unused. It consumes bytes from the UART receiver, parses a small packet header, and writes the payload bytes sequentially into the 4096x8 port-A view of the framebuffer. It runs on the root clock. Its outputs connect directly to the RAM's AddressA/DataInA/ClockEnA/WrA; the fetch/scan path on port B is unaffected.

---
 rtl/framebuffer_loader.sv | 164 ++++++++++++++++
 tb/tb_framebuffer_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_loader.sv
// framebuffer_loader
//   Receives a byte stream from the UART receiver, parses the packet header
//   (SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO) and writes the payload bytes one
//   after another into the 4096x8 port-A view of the framebuffer.
//
// Ports
//   clk_in          root clock, rising edge
//   reset           synchronous, active-high
//   rx_data[7:0]    received byte, valid while rx_strobe is high
//   rx_strobe       one-cycle pulse per received byte
//   ram_address     port-A byte address (held between writes)
//   ram_data_out    port-A write data   (held between writes)
//   ram_clk_enable  port-A clock enable, high only in a write cycle
//   ram_write       port-A write enable, same timing as ram_clk_enable
//   busy            high whenever the parser is not in IDLE
//   frame_done      one-cycle pulse together with the final payload write
//   error           one-cycle pulse when a stalled packet is abandoned
//
// Handshake: rx_strobe is a valid-only pulse. There is no ready; every
// strobed byte is consumed in the cycle it is presented, and the matching
// write appears on the RAM port in the following cycle.
module framebuffer_loader #(
  parameter logic [7:0]               SYNC_BYTE      = 8'hA5,
  parameter int                       TIMEOUT_WIDTH  = 20,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  output logic [11:0] ram_address,
  output logic [7:0]  ram_data_out,
  output logic        ram_clk_enable,
  output logic        ram_write,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_LEN_HI  = 3'd3,
    S_LEN_LO  = 3'd4,
    S_DATA    = 3'd5
  } state_t;

  // The counter is compared against TIMEOUT_CYCLES-1 so that the abort lands
  // on the edge where the idle count would reach TIMEOUT_CYCLES.
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);

  state_t                   state, state_next;
  logic [3:0]               addr_hi, addr_hi_next;
  logic [3:0]               len_hi, len_hi_next;
  logic [11:0]              ptr, ptr_next;
  logic [11:0]              remaining, remaining_next;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt, idle_cnt_next;
  logic [11:0]              address_next;
  logic [7:0]               data_next;
  logic                     write_next;
  logic                     frame_done_next;
  logic                     error_next;
  logic                     timeout_hit;

  // A strobe in the same cycle always beats the timeout.
  assign timeout_hit = !rx_strobe && (state != S_IDLE) && (idle_cnt == TIMEOUT_LAST);

  assign busy = (state != S_IDLE);

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state          <= S_IDLE;
      addr_hi        <= '0;
      len_hi         <= '0;
      ptr            <= '0;
      remaining      <= '0;
      idle_cnt       <= '0;
      ram_address    <= '0;
      ram_data_out   <= '0;
      ram_clk_enable <= 1'b0;
      ram_write      <= 1'b0;
      frame_done     <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_next;
      addr_hi        <= addr_hi_next;
      len_hi         <= len_hi_next;
      ptr            <= ptr_next;
      remaining      <= remaining_next;
      idle_cnt       <= idle_cnt_next;
      ram_address    <= address_next;
      ram_data_out   <= data_next;
      ram_clk_enable <= write_next;
      ram_write      <= write_next;
      frame_done     <= frame_done_next;
      error          <= error_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (rx_strobe) begin
      case (state)
        S_IDLE:    if (rx_data == SYNC_BYTE) state_next = S_ADDR_HI;
        S_ADDR_HI: state_next = S_ADDR_LO;
        S_ADDR_LO: state_next = S_LEN_HI;
        S_LEN_HI:  state_next = S_LEN_LO;
        S_LEN_LO:  state_next = S_DATA;
        S_DATA:    if (remaining == 12'd0) state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = S_IDLE;
    end
  end

  // Datapath / output next values.
  always_comb begin
    addr_hi_next    = addr_hi;
    len_hi_next     = len_hi;
    ptr_next        = ptr;
    remaining_next  = remaining;
    address_next    = ram_address;
    data_next       = ram_data_out;
    write_next      = 1'b0;
    frame_done_next = 1'b0;
    error_next      = 1'b0;

    if (rx_strobe || (state == S_IDLE) || timeout_hit) begin
      idle_cnt_next = '0;
    end else begin
      idle_cnt_next = idle_cnt + TIMEOUT_WIDTH'(1);
    end

    if (rx_strobe) begin
      case (state)
        S_ADDR_HI: addr_hi_next   = rx_data[3:0];
        S_ADDR_LO: ptr_next       = {addr_hi, rx_data};
        S_LEN_HI:  len_hi_next    = rx_data[3:0];
        // remaining holds (bytes left - 1); zero marks the last byte.
        S_LEN_LO:  remaining_next = {len_hi, rx_data};
        S_DATA: begin
          write_next   = 1'b1;
          address_next = ptr;
          data_next    = rx_data;
          ptr_next     = ptr + 12'd1;
          if (remaining == 12'd0) begin
            frame_done_next = 1'b1;
          end else begin
            remaining_next = remaining - 12'd1;
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      error_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_framebuffer_loader.sv
module tb_framebuffer_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 100;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_out;
  logic        ram_clk_enable;
  logic        ram_write;
  logic        busy;
  logic        frame_done;
  logic        error;

  framebuffer_loader #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_WIDTH  (20),
    .TIMEOUT_CYCLES (20'd100)
  ) dut (
    .clk_in         (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_strobe      (rx_strobe),
    .ram_address    (ram_address),
    .ram_data_out   (ram_data_out),
    .ram_clk_enable (ram_clk_enable),
    .ram_write      (ram_write),
    .busy           (busy),
    .frame_done     (frame_done),
    .error          (error)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected write entries: {sample cycle, frame_done, address, data}.
  logic [52:0] exp_q[$];

  // ---------------- reference model (byte-stream parser) ----------------
  bit         m_active;
  int         m_hdr_n;
  logic [7:0] m_hdr [4];
  int         m_left;
  int         m_ptr;

  task automatic model_reset();
    m_active = 0;
    m_hdr_n  = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    logic [31:0] cc;
    if (!m_active) begin
      if (b == SYNC) begin
        m_active = 1;
        m_hdr_n  = 0;
      end
    end else if (m_hdr_n < 4) begin
      m_hdr[m_hdr_n] = b;
      m_hdr_n++;
      if (m_hdr_n == 4) begin
        m_ptr  = int'(m_hdr[0][3:0]) * 256 + int'(m_hdr[1]);
        m_left = int'(m_hdr[2][3:0]) * 256 + int'(m_hdr[3]) + 1;
      end
    end else begin
      m_left--;
      cc = c;
      exp_q.push_back({cc, (m_left == 0), 12'(m_ptr), b});
      m_ptr = (m_ptr + 1) % 4096;
      if (m_left == 0) m_active = 0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          wr_count   = 0;
  int          done_count = 0;
  int          err_count  = 0;
  int          err_cyc    = 0;
  logic [11:0] last_addr  = '0;
  logic [7:0]  last_data  = '0;

  always @(negedge clk) begin
    logic [52:0] e;
    logic [31:0] cc;
    if (ram_write || ram_clk_enable) check("we_equals_ce", ram_write, ram_clk_enable);
    if (ram_write) begin
      wr_count++;
      last_addr = ram_address;
      last_data = ram_data_out;
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        cc = cyc;
        check("write_cyc_done_addr_data", {cc, frame_done, ram_address, ram_data_out}, e);
      end
    end
    if (frame_done) begin
      done_count++;
      check("done_with_write", ram_write, 1);
    end
    if (error) begin
      err_count++;
      err_cyc = cyc;
    end
  end

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    model_byte(b, cyc + 1);
    @(posedge clk);
    #1;
    rx_strobe = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_addr"}, ram_address, 0);
    check({name, "_data"}, ram_data_out, 0);
    check({name, "_ce"}, ram_clk_enable, 0);
    check({name, "_we"}, ram_write, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, frame_done, 0);
    check({name, "_err"}, error, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [79:0] b;       // bytes, first byte in the top 8 bits
    int          n;
    int          exp_wr;
    logic [11:0] last_a;
    logic [7:0]  last_d;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int wr0, done0, err0, c_s;
    logic [7:0] v;

    vecs[0] = '{{8'hA5, 8'h01, 8'h23, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 16'h0}, 8, 3, 12'h125, 8'hCC};
    vecs[1] = '{{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h22, 24'h0}, 7, 2, 12'h000, 8'h22};
    vecs[2] = '{{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'hA5, 8'h0}, 9, 1, 12'h010, 8'hA5};
    vecs[3] = '{{8'hA5, 8'hF0, 8'h00, 8'hF0, 8'h00, 8'h5A, 32'h0}, 6, 1, 12'h000, 8'h5A};
    vecs[4] = '{{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 24'h0}, 7, 2, 12'h5A6, 8'hA5};

    reset     = 1'b1;
    rx_strobe = 1'b0;
    rx_data   = 8'h00;
    model_reset();
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;

    // Table-driven packets, all bytes back-to-back.
    for (int i = 0; i < 5; i++) begin
      wr0   = wr_count;
      done0 = done_count;
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[79-8*k -: 8]);
      idle(3);
      check($sformatf("vec%0d_writes", i), wr_count - wr0, vecs[i].exp_wr);
      check($sformatf("vec%0d_done", i), done_count - done0, 1);
      check($sformatf("vec%0d_last_addr", i), last_addr, vecs[i].last_a);
      check($sformatf("vec%0d_last_data", i), last_data, vecs[i].last_d);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Reset in the middle of DATA.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h31); send_byte(8'h32);
    idle(1);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_addr", ram_address, 12'h002);
    reset = 1'b1;
    model_reset();
    idle(1);
    reset = 1'b0;
    check_all_zero("mid_reset");
    wr0 = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h11);
    idle(2);
    check("after_reset_writes", wr_count - wr0, 1);
    check("after_reset_addr", last_addr, 12'h000);
    check("after_reset_data", last_data, 8'h11);

    // Timeout during DATA.
    err0 = err_count;
    wr0  = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h01);
    c_s = cyc;
    for (int k = 0; k < 2 * TMO && err_count == err0; k++) idle(1);
    check("timeout_seen", err_count - err0, 1);
    check("timeout_cycle", err_cyc - c_s, TMO);
    model_reset();
    check("timeout_busy", busy, 0);
    idle(TMO + 20);
    check("timeout_single_pulse", err_count - err0, 1);
    check("timeout_writes", wr_count - wr0, 1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h77); send_byte(8'h88);
    idle(2);
    check("post_timeout_last_addr", last_addr, 12'h021);
    check("post_timeout_last_data", last_data, 8'h88);

    // Strobe arriving exactly on the timeout cycle wins.
    err0 = err_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h30);
    send_byte(8'h00); send_byte(8'h01);
    idle(TMO - 1);
    send_byte(8'h44);
    idle(TMO - 1);
    send_byte(8'h55);
    idle(2);
    check("strobe_wins_no_error", err_count - err0, 0);
    check("strobe_wins_last_addr", last_addr, 12'h031);
    check("strobe_wins_last_data", last_data, 8'h55);

    // Randomized packets with junk bytes and small gaps.
    for (int p = 0; p < 25; p++) begin
      int junk, len;
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        v = 8'($urandom_range(0, 255));
        if (v == SYNC) v = 8'h00;
        send_byte(v);
        idle($urandom_range(0, 3));
      end
      len = $urandom_range(0, 15);
      send_byte(SYNC);
      send_byte(8'($urandom_range(0, 255)));
      send_byte(8'($urandom_range(0, 255)));
      send_byte({4'($urandom_range(0, 15)), 4'h0});
      send_byte(8'(len));
      for (int k = 0; k <= len; k++) begin
        send_byte(8'($urandom_range(0, 255)));
        idle($urandom_range(0, 3));
      end
    end
    idle(3);
    check("random_busy", busy, 0);

    // Full 4096-byte frame, back-to-back.
    wr0   = wr_count;
    done0 = done_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h0F); send_byte(8'hFF);
    for (int k = 0; k < 4096; k++) send_byte(8'(k));
    idle(3);
    check("full_writes", wr_count - wr0, 4096);
    check("full_done", done_count - done0, 1);
    check("full_last_addr", last_addr, 12'hFFF);
    check("full_last_data", last_data, 8'hFF);
    check("full_busy", busy, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
